// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup and EX-side resolve/update bundle for the BTB predictor.
// Valid/ready semantics: no ready; upd_en is a one-cycle valid sampled on the rising clk edge.
interface branch_predictor_btb_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] if_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_en;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_mispredict;
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;

  modport master (
    output if_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_hit, pred_taken, pred_target, stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_hit, pred_taken, pred_target, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating counters, zero-latency lookup, EX-stage update.
// Optional resolved/mispredict statistics counters are built when BP_STATS_EN is defined.
module branch_predictor_btb #(
  parameter int INDEX_BITS = 4,
  parameter int PC_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_predictor_btb_if.slave bus
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_W - INDEX_BITS - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [TAG_W-1:0]      up_tag;
  logic                  lk_hit;
  logic                  lk_taken;
  logic                  up_hit;
  logic [1:0]            ctr_d;
  logic                  unused_pc_lsbs;

  assign lk_idx = bus.if_pc[INDEX_BITS+1:2];
  assign lk_tag = bus.if_pc[PC_W-1:INDEX_BITS+2];
  assign up_idx = bus.upd_pc[INDEX_BITS+1:2];
  assign up_tag = bus.upd_pc[PC_W-1:INDEX_BITS+2];
  assign unused_pc_lsbs = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

  // Lookup reads registered state only, so a same-edge update is not bypassed.
  assign lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken        = lk_hit && ctr_q[lk_idx][1];
  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_taken;
  assign bus.pred_target = lk_taken ? target_q[lk_idx] : bus.if_pc + PC_W'(4);

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    ctr_d = ctr_q[up_idx];
    if (bus.upd_taken) begin
      if (ctr_q[up_idx] != 2'b11) ctr_d = ctr_q[up_idx] + 2'd1;
    end else begin
      if (ctr_q[up_idx] != 2'b00) ctr_d = ctr_q[up_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bus.upd_en) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_d;
        if (bus.upd_taken) target_q[up_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        // Taken miss evicts whatever occupies the slot and starts weakly taken.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.upd_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] br_cnt_d;
  logic [31:0] mis_cnt_q;
  logic [31:0] mis_cnt_d;

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (bus.upd_en) begin
      if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
      if (bus.upd_mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign bus.stat_branches    = br_cnt_q;
  assign bus.stat_mispredicts = mis_cnt_q;
`else
  logic unused_stat_in;
  assign unused_stat_in       = bus.upd_mispredict;
  assign bus.stat_branches    = '0;
  assign bus.stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: reference model, expected queue, summary line.
module tb_branch_predictor_btb;
  localparam int PC_W = 32;
  localparam int IB   = 4;
  localparam int N    = 1 << IB;
  localparam int W    = 2 + PC_W;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  branch_predictor_btb_if #(.PC_W(PC_W)) bus ();

  branch_predictor_btb #(.INDEX_BITS(IB), .PC_W(PC_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic            m_valid [N];
  logic [PC_W-1:0] m_pc    [N];
  logic [PC_W-1:0] m_tgt   [N];
  int              m_ctr   [N];
  int              m_br;
  int              m_mis;

  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endtask

  function automatic logic [W-1:0] m_lookup(input logic [PC_W-1:0] pc);
    int i;
    logic hit, tk;
    logic [PC_W-1:0] tgt;
    i   = int'(pc[IB+1:2]);
    hit = m_valid[i] && (m_pc[i][PC_W-1:IB+2] == pc[PC_W-1:IB+2]);
    tk  = hit && (m_ctr[i] >= 2);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
    return {hit, tk, tgt};
  endfunction

  task automatic m_update(input logic [PC_W-1:0] pc, input logic tk,
                          input logic [PC_W-1:0] tgt, input logic mis);
    int i;
    logic hit;
    i   = int'(pc[IB+1:2]);
    hit = m_valid[i] && (m_pc[i][PC_W-1:IB+2] == pc[PC_W-1:IB+2]);
    m_br++;
    if (mis) m_mis++;
    if (hit) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1; m_pc[i] = pc; m_tgt[i] = tgt; m_ctr[i] = 2;
    end
  endtask

  // driver tasks
  task automatic drive_lookup(input logic [PC_W-1:0] pc);
    bus.if_pc = pc;
    exp_q.push_back(m_lookup(pc));
  endtask

  task automatic sample_lookup(input string tag);
    logic [W-1:0] e;
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hit"},    64'(bus.pred_hit),    64'(e[W-1]));
      check({tag, "_taken"},  64'(bus.pred_taken),  64'(e[W-2]));
      check({tag, "_target"}, 64'(bus.pred_target), 64'(e[PC_W-1:0]));
    end
  endtask

  task automatic lookup(input logic [PC_W-1:0] pc, input string tag);
    @(negedge clk);
    drive_lookup(pc);
    sample_lookup(tag);
  endtask

  task automatic update(input logic [PC_W-1:0] pc, input logic tk,
                        input logic [PC_W-1:0] tgt, input logic mis);
    @(negedge clk);
    bus.upd_en = 1'b1; bus.upd_pc = pc; bus.upd_taken = tk;
    bus.upd_target = tgt; bus.upd_mispredict = mis;
    @(posedge clk);
    m_update(pc, tk, tgt, mis);
    #1;
    bus.upd_en = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    @(negedge clk);
`ifdef BP_STATS_EN
    check({tag, "_br"},  64'(bus.stat_branches),    64'(m_br));
    check({tag, "_mis"}, 64'(bus.stat_mispredicts), 64'(m_mis));
`else
    check({tag, "_br"},  64'(bus.stat_branches),    64'd0);
    check({tag, "_mis"}, 64'(bus.stat_mispredicts), 64'd0);
`endif
  endtask

  // stimulus
  initial begin
    logic [PC_W-1:0] pcs [6];
    pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h184;
    pcs[3] = 32'h1C4; pcs[4] = 32'h3FC; pcs[5] = 32'h7000_0010;
    checks = 0; errors = 0;
    bus.if_pc = '0; bus.upd_en = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_target = '0; bus.upd_mispredict = 1'b0;
    m_reset();
    reset = 1'b1;
    // an update held across an edge during reset must be discarded
    @(negedge clk);
    bus.upd_en = 1'b1; bus.upd_pc = 32'h100; bus.upd_taken = 1'b1; bus.upd_target = 32'h80;
    repeat (2) @(negedge clk);
    bus.upd_en = 1'b0;
    drive_lookup(32'h100);
    sample_lookup("rst");
    check("rst_tgt_const", 64'(bus.pred_target), 64'h104);
    check_stats("rst");
    reset = 1'b0;

    lookup(32'h100, "cold");
    update(32'h100, 1'b1, 32'h80, 1'b1);
    lookup(32'h100, "alloc");
    check("alloc_tgt_const", 64'(bus.pred_target), 64'h80);
    update(32'h100, 1'b0, 32'h80, 1'b1);
    lookup(32'h100, "wnt");
    check("wnt_taken_const", 64'(bus.pred_taken), 64'd0);
    repeat (3) update(32'h100, 1'b1, 32'h80, 1'b0);
    lookup(32'h100, "snt3");
    update(32'h100, 1'b0, 32'h80, 1'b1);
    lookup(32'h100, "st_nt");
    check("st_nt_taken_const", 64'(bus.pred_taken), 64'd1);

    // same-edge lookup and update: lookup sees pre-update state
    @(negedge clk);
    drive_lookup(32'h100);
    bus.upd_en = 1'b1; bus.upd_pc = 32'h100; bus.upd_taken = 1'b0;
    bus.upd_target = 32'h80; bus.upd_mispredict = 1'b1;
    sample_lookup("same_pre");
    @(posedge clk);
    m_update(32'h100, 1'b0, 32'h80, 1'b1);
    #1 bus.upd_en = 1'b0;
    lookup(32'h100, "same_post");
    check("same_post_const", 64'(bus.pred_taken), 64'd0);

    // alias eviction at index 0
    update(32'h100, 1'b1, 32'h80, 1'b0);
    update(32'h140, 1'b1, 32'h200, 1'b0);
    lookup(32'h100, "alias_old");
    check("alias_old_const", 64'(bus.pred_target), 64'h104);
    lookup(32'h140, "alias_new");
    check("alias_new_const", 64'(bus.pred_target), 64'h200);
    lookup(32'h142, "lsb_ignored");

    update(32'h208, 1'b0, 32'h300, 1'b0);
    lookup(32'h208, "miss_nt");
    check("miss_nt_const", 64'(bus.pred_hit), 64'd0);
    lookup(32'hFFFF_FFFC, "wrap");
    check("wrap_const", 64'(bus.pred_target), 64'h0);
    check_stats("dir");

    // random mix
    for (int k = 0; k < 150; k++) begin
      int s;
      s = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1)
        update(pcs[s], 1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'hFFFF)) & 32'hFFFC,
               1'($urandom_range(0, 1)));
      lookup(pcs[$urandom_range(0, 5)], "rnd");
    end
    check_stats("rnd");

    // stats from clean reset, then async reset mid-sequence
    @(negedge clk);
    reset = 1'b1; m_reset();
    @(negedge clk);
    reset = 1'b0;
    update(32'h100, 1'b1, 32'h80, 1'b1);
    update(32'h104, 1'b1, 32'h90, 1'b0);
    update(32'h100, 1'b0, 32'h80, 1'b1);
    update(32'h108, 1'b0, 32'hA0, 1'b0);
    update(32'h104, 1'b1, 32'h90, 1'b0);
    check_stats("five");
`ifdef BP_STATS_EN
    check("five_br_const", 64'(bus.stat_branches), 64'd5);
    check("five_mis_const", 64'(bus.stat_mispredicts), 64'd2);
`endif
    @(negedge clk);
    bus.if_pc = 32'h104;
    bus.upd_en = 1'b1; bus.upd_pc = 32'h104; bus.upd_taken = 1'b1;
    bus.upd_target = 32'h90; bus.upd_mispredict = 1'b1;
    #2 reset = 1'b1;
    m_reset();
    #1;
    check("async_br",  64'(bus.stat_branches),    64'd0);
    check("async_mis", 64'(bus.stat_mispredicts), 64'd0);
    check("async_hit", 64'(bus.pred_hit),         64'd0);
    @(negedge clk);
    bus.upd_en = 1'b0;
    reset = 1'b0;
    lookup(32'h104, "post_rst");
    check_stats("post_rst");

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Looked up combinationally with the IF-stage PC. Produces the taken prediction that travels down the pipeline to the EX-stage branch resolver as its prediction bit.
- Updated by that resolver once a branch's actual outcome and target are known in EX.

Parameters:
- INDEX_BITS, 4, log2 of entry count (16 entries).
- PC_W, 32, PC and target width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all predictor state.
- if_pc  input  PC_W  PC of the instruction in IF.
- pred_hit  output  1  if_pc matches a valid BTB entry.
- pred_taken  output  1  prediction; sent down the pipeline as the ID/EX prediction bit.
- pred_target  output  PC_W  next-fetch address: BTB target if predicted taken, else if_pc+4.
- upd_en  input  1  a conditional branch resolved in EX this cycle.
- upd_pc  input  PC_W  PC of the resolved branch.
- upd_taken  input  1  actual outcome.
- upd_target  input  PC_W  actual taken target (pc + (imm<<1)).
- upd_mispredict  input  1  resolver flagged a flush for this branch.
- stat_branches  output  32  resolved-branch count (see Optional Feature).
- stat_mispredicts  output  32  misprediction count (see Optional Feature).

Behaviour:
- Index = pc[INDEX_BITS+1:2]; tag = pc[PC_W-1:INDEX_BITS+2]. pc[1:0] is ignored.
- Per entry state:
  - valid: 1 bit.
  - tag: PC_W-INDEX_BITS-2 bits.
  - target: PC_W bits.
  - ctr: 2 bits, encoded 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is purely combinational from registered state (zero latency):
  - pred_hit = valid[idx] & (tag[idx]==tag(if_pc)).
  - pred_taken = pred_hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4, with modulo-2^PC_W wrap (0xFFFFFFFC -> 0x00000000).
- Reset (async, any time, including mid-update):
  - All valid=0, ctr=01, target=0, tag=0.
  - Hence pred_hit=0, pred_taken=0, pred_target=if_pc+4, stats=0.
  - An upd_en coincident with reset assertion or release edge is discarded.
- Update is applied on the rising clk edge when upd_en=1:
  - Hit (valid & tag match): ctr increments if upd_taken, saturating at 11; decrements if !upd_taken, saturating at 00. If upd_taken, target <= upd_target.
  - Miss & upd_taken: allocate and overwrite any occupant. valid=1, tag, target=upd_target, ctr=10.
  - Miss & !upd_taken: no state change.
- upd_en=0: no state change; upd_* and upd_mispredict are ignored.
- Update latency: visible to lookup in the cycle after the edge.
- Same-cycle lookup and update of the same index: lookup returns pre-update state. There is no write-to-read bypass.
- Aliasing: two PCs with the same index but different tags evict each other. Only the tag distinguishes them.
- No stall input: the table is insensitive to pipeline stalls. The updater guarantees one upd_en pulse per resolved branch.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - stat_branches increments on each clk edge with upd_en=1.
  - stat_mispredicts increments when upd_en & upd_mispredict.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: no counter logic; both outputs are tied to 0. Ports are retained so the top level is unchanged.

Test Plan:
- Reset, then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
- upd_en, upd_pc=0x100, taken, target=0x80; next cycle if_pc=0x100 -> hit=1, taken=1, target=0x80 (ctr=10).
- From ctr=10: one not-taken update for 0x100 -> ctr=01, pred_taken=0, pred_target=0x104, hit=1. Then three taken updates -> ctr=11. One not-taken -> still pred_taken=1 (ctr=10).
- Alias: train 0x100 taken, then update 0x140 taken, target 0x200 (same index, INDEX_BITS=4) -> 0x100 misses (target 0x104); 0x140 hits with target 0x200.
- Same edge: if_pc=0x100 while upd_en for 0x100 not-taken from ctr=10 -> that cycle pred_taken=1; next cycle pred_taken=0. Miss and not-taken update on an empty index -> entry stays invalid.
- BP_STATS_EN: 5 upd_en pulses, 2 with upd_mispredict -> stat_branches=5, stat_mispredicts=2. Assert reset mid-sequence -> both 0 immediately (async). Without the macro both read 0 throughout.
